// File: rtl/mdma_ecc_sdp_ram.sv
// Simple-dual-port RAM with SECDED protection, write-side error injection, optional
// scrub write-back of corrected words and saturating error counters.
module mdma_ecc_sdp_ram #(
  parameter int unsigned DATA_W = 80,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wen_i,
  input  logic [ADDR_W-1:0] wadr_i,
  input  logic [DATA_W-1:0] wdat_i,
  input  logic              ren_i,
  input  logic [ADDR_W-1:0] radr_i,
  output logic [DATA_W-1:0] rdat_o,
  output logic              rvld_o,
  output logic              rsbe_o,
  output logic              rdbe_o,
  input  logic              inj_sbe_i,
  input  logic              inj_dbe_i,
  input  logic              scrub_en_i,
  input  logic              cnt_clr_i,
  output logic [CNT_W-1:0]  sbe_cnt_o,
  output logic [CNT_W-1:0]  dbe_cnt_o,
  output logic              scrub_drop_o
);

  function automatic int ham_bits(input int dw);
    int p;
    p = 1;
    while ((1 << p) < (dw + p + 1)) p++;
    return p;
  endfunction

  localparam int HAM_W  = ham_bits(int'(DATA_W));
  localparam int ECC_W  = HAM_W + 1;
  localparam int CW_N   = int'(DATA_W) + HAM_W;
  localparam int WORD_W = int'(DATA_W) + ECC_W;

  // Hamming bits sit at power-of-two positions, data fills the rest in order.
  function automatic logic [ECC_W-1:0] ecc_enc(input logic [DATA_W-1:0] d);
    logic [CW_N:1]    cw;
    logic [ECC_W-1:0] e;
    int               k;
    cw = '0;
    e  = '0;
    k  = 0;
    for (int pos = 1; pos <= CW_N; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = d[k];
        k++;
      end
    end
    for (int i = 0; i < HAM_W; i++) begin
      for (int pos = 1; pos <= CW_N; pos++) begin
        if (((pos >> i) & 1) == 1) e[i] = e[i] ^ cw[pos];
      end
    end
    e[ECC_W-1] = ^{d, e[HAM_W-1:0]};
    return e;
  endfunction

  // Returns {dbe, sbe, corrected_or_raw_data}.
  function automatic logic [DATA_W+1:0] ecc_dec(input logic [WORD_W-1:0] w);
    logic [DATA_W-1:0] d;
    logic [ECC_W-1:0]  chk;
    logic [HAM_W-1:0]  syn;
    logic              par, sbe, dbe;
    int                k;
    d   = w[DATA_W-1:0];
    chk = ecc_enc(d);
    syn = w[DATA_W +: HAM_W] ^ chk[HAM_W-1:0];
    par = ^w;
    sbe = 1'b0;
    dbe = 1'b0;
    k   = 0;
    if (par) begin
      sbe = 1'b1;
      for (int pos = 1; pos <= CW_N; pos++) begin
        if ((pos & (pos - 1)) != 0) begin
          if (pos == int'(syn)) d[k] = ~d[k];
          k++;
        end
      end
    end else if (syn != '0) begin
      dbe = 1'b1;
    end
    return {dbe, sbe, d};
  endfunction

  logic [WORD_W-1:0] mem_q [DEPTH];

  logic              arm_sbe_q, arm_dbe_q;
  logic [DATA_W-1:0] flip;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wadr;
  logic [WORD_W-1:0] mem_wword;
  logic              scrub_req, scrub_go;
  logic [ADDR_W-1:0] out_adr;
  logic              out_stale;

  always_comb begin
    flip = '0;
    if (arm_dbe_q || inj_dbe_i) begin
      flip[1:0] = 2'b11;
    end else if (arm_sbe_q || inj_sbe_i) begin
      flip[0] = 1'b1;
    end
  end

  // User writes always win the single write port; scrubs only fill idle cycles.
  always_comb begin
    mem_we    = wen_i | scrub_go;
    mem_wadr  = wadr_i;
    mem_wword = {ecc_enc(wdat_i), wdat_i ^ flip};
    if (!wen_i) begin
      mem_wadr  = out_adr;
      mem_wword = {ecc_enc(rdat_o), rdat_o};
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[mem_wadr] <= mem_wword;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      arm_sbe_q <= 1'b0;
      arm_dbe_q <= 1'b0;
    end else if (wen_i) begin
      arm_sbe_q <= 1'b0;
      arm_dbe_q <= 1'b0;
    end else begin
      arm_sbe_q <= arm_sbe_q | inj_sbe_i;
      arm_dbe_q <= arm_dbe_q | inj_dbe_i;
    end
  end

  logic              rd_vld_q, rd_stale_q;
  logic [ADDR_W-1:0] rd_adr_q;
  logic [WORD_W-1:0] rd_word_q;
  logic [DATA_W+1:0] dec;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_vld_q   <= 1'b0;
      rd_stale_q <= 1'b0;
      rd_adr_q   <= '0;
      rd_word_q  <= '0;
    end else begin
      rd_vld_q <= ren_i;
      if (ren_i) begin
        rd_word_q  <= mem_q[radr_i];
        rd_adr_q   <= radr_i;
        rd_stale_q <= wen_i && (wadr_i == radr_i);
      end
    end
  end

  assign dec = ecc_dec(rd_word_q);

  if (RD_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] rdat_q;
    logic              rvld_q, rsbe_q, rdbe_q, stale_q;
    logic [ADDR_W-1:0] adr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rdat_q  <= '0;
        rvld_q  <= 1'b0;
        rsbe_q  <= 1'b0;
        rdbe_q  <= 1'b0;
        stale_q <= 1'b0;
        adr_q   <= '0;
      end else begin
        rvld_q <= rd_vld_q;
        rsbe_q <= rd_vld_q & dec[DATA_W];
        rdbe_q <= rd_vld_q & dec[DATA_W+1];
        if (rd_vld_q) begin
          rdat_q  <= dec[DATA_W-1:0];
          adr_q   <= rd_adr_q;
          stale_q <= rd_stale_q | (wen_i && (wadr_i == rd_adr_q));
        end
      end
    end

    assign rdat_o    = rdat_q;
    assign rvld_o    = rvld_q;
    assign rsbe_o    = rsbe_q;
    assign rdbe_o    = rdbe_q;
    assign out_adr   = adr_q;
    assign out_stale = stale_q;
  end else begin : g_lat1
    assign rdat_o    = dec[DATA_W-1:0];
    assign rvld_o    = rd_vld_q;
    assign rsbe_o    = rd_vld_q & dec[DATA_W];
    assign rdbe_o    = rd_vld_q & dec[DATA_W+1];
    assign out_adr   = rd_adr_q;
    assign out_stale = rd_stale_q;
  end

  assign scrub_req    = scrub_en_i & rsbe_o & ~out_stale;
  assign scrub_go     = scrub_req & ~wen_i;
  assign scrub_drop_o = scrub_req & wen_i;

  logic [CNT_W-1:0] sbe_cnt_q, dbe_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sbe_cnt_q <= '0;
      dbe_cnt_q <= '0;
    end else if (cnt_clr_i) begin
      sbe_cnt_q <= '0;
      dbe_cnt_q <= '0;
    end else begin
      if (rsbe_o && (sbe_cnt_q != '1)) sbe_cnt_q <= sbe_cnt_q + CNT_W'(1);
      if (rdbe_o && (dbe_cnt_q != '1)) dbe_cnt_q <= dbe_cnt_q + CNT_W'(1);
    end
  end

  assign sbe_cnt_o = sbe_cnt_q;
  assign dbe_cnt_o = dbe_cnt_q;

endmodule

// File: tb/tb_mdma_ecc_sdp_ram.sv
// Bench for mdma_ecc_sdp_ram: a latency-1 and a latency-2/2-bit-counter instance share
// stimulus and are checked against a transaction-level model of contents and error state.
module tb_mdma_ecc_sdp_ram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wen, ren, inj_sbe, inj_dbe, scrub_en, cnt_clr;
  logic [8:0]  wadr, radr;
  logic [79:0] wdat;

  logic [79:0] rdat1, rdat2;
  logic        rvld1, rsbe1, rdbe1, drop1;
  logic        rvld2, rsbe2, rdbe2, drop2;
  logic [15:0] sbe_cnt1, dbe_cnt1;
  logic [1:0]  sbe_cnt2, dbe_cnt2;

  always #5 clk = ~clk;

  mdma_ecc_sdp_ram #(.RD_LAT(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .wen_i(wen), .wadr_i(wadr), .wdat_i(wdat),
    .ren_i(ren), .radr_i(radr), .rdat_o(rdat1), .rvld_o(rvld1), .rsbe_o(rsbe1),
    .rdbe_o(rdbe1), .inj_sbe_i(inj_sbe), .inj_dbe_i(inj_dbe), .scrub_en_i(scrub_en),
    .cnt_clr_i(cnt_clr), .sbe_cnt_o(sbe_cnt1), .dbe_cnt_o(dbe_cnt1), .scrub_drop_o(drop1)
  );

  mdma_ecc_sdp_ram #(.RD_LAT(2), .CNT_W(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .wen_i(wen), .wadr_i(wadr), .wdat_i(wdat),
    .ren_i(ren), .radr_i(radr), .rdat_o(rdat2), .rvld_o(rvld2), .rsbe_o(rsbe2),
    .rdbe_o(rdbe2), .inj_sbe_i(inj_sbe), .inj_dbe_i(inj_dbe), .scrub_en_i(scrub_en),
    .cnt_clr_i(cnt_clr), .sbe_cnt_o(sbe_cnt2), .dbe_cnt_o(dbe_cnt2), .scrub_drop_o(drop2)
  );

  // st: 0 clean, 1 stored with data bit 0 flipped, 2 stored with data bits 1:0 flipped.
  typedef struct {
    int unsigned due;
    logic [8:0]  adr;
    logic [79:0] data;
    int          st;
    bit          stale;
  } rd_t;

  rd_t         q1[$], q2[$];
  logic [79:0] mdata [512];
  int          est1 [512], est2 [512];
  bit          arm_s, arm_d;
  int          c1s, c1d, c2s, c2d;
  int unsigned cyc;
  int          checks, errors;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic out_check(input int d, input logic vld, input logic [79:0] dat,
                           input logic sbe, input logic dbe, input logic drop,
                           input int sc, input int dc);
    rd_t e;
    bit  have;
    bit  exp_drop;
    int  cmax;
    have     = 0;
    exp_drop = 0;
    cmax     = (d == 1) ? 65535 : 3;
    if (d == 1 && q1.size() > 0 && q1[0].due == cyc) begin
      e = q1.pop_front();
      have = 1;
    end
    if (d == 2 && q2.size() > 0 && q2[0].due == cyc) begin
      e = q2.pop_front();
      have = 1;
    end
    chk($sformatf("d%0d_rvld@%0d", d, cyc), 128'(vld), 128'(have));
    if (have) chk($sformatf("d%0d_rdat@%0d", d, cyc), 128'(dat),
                  128'((e.st == 2) ? (e.data ^ 80'h3) : e.data));
    chk($sformatf("d%0d_rsbe@%0d", d, cyc), 128'(sbe), 128'(have && e.st == 1));
    chk($sformatf("d%0d_rdbe@%0d", d, cyc), 128'(dbe), 128'(have && e.st == 2));
    if (have && e.st == 1 && scrub_en && !e.stale) begin
      if (wen) exp_drop = 1;
      else if (d == 1) est1[e.adr] = 0;
      else est2[e.adr] = 0;
    end
    chk($sformatf("d%0d_drop@%0d", d, cyc), 128'(drop), 128'(exp_drop));
    if (d == 1) begin
      chk($sformatf("d1_sbecnt@%0d", cyc), 128'(sc), 128'(c1s));
      chk($sformatf("d1_dbecnt@%0d", cyc), 128'(dc), 128'(c1d));
      if (cnt_clr) begin c1s = 0; c1d = 0; end
      else if (have && e.st == 1 && c1s < cmax) c1s++;
      else if (have && e.st == 2 && c1d < cmax) c1d++;
    end else begin
      chk($sformatf("d2_sbecnt@%0d", cyc), 128'(sc), 128'(c2s));
      chk($sformatf("d2_dbecnt@%0d", cyc), 128'(dc), 128'(c2d));
      if (cnt_clr) begin c2s = 0; c2d = 0; end
      else if (have && e.st == 1 && c2s < cmax) c2s++;
      else if (have && e.st == 2 && c2d < cmax) c2d++;
    end
  endtask

  // One clock cycle: check outputs against the model, then apply this cycle's edge.
  task automatic step();
    rd_t l1, l2;
    bit  launch;
    int  st;
    @(negedge clk);
    launch = ren;
    if (launch) begin
      l1.due = cyc + 1; l1.adr = radr; l1.data = mdata[radr]; l1.st = est1[radr]; l1.stale = 0;
      l2.due = cyc + 2; l2.adr = radr; l2.data = mdata[radr]; l2.st = est2[radr]; l2.stale = 0;
    end
    out_check(1, rvld1, rdat1, rsbe1, rdbe1, drop1, int'(sbe_cnt1), int'(dbe_cnt1));
    out_check(2, rvld2, rdat2, rsbe2, rdbe2, drop2, int'(sbe_cnt2), int'(dbe_cnt2));
    if (launch) begin
      q1.push_back(l1);
      q2.push_back(l2);
    end
    if (wen) begin
      foreach (q1[i]) if (q1[i].adr == wadr) q1[i].stale = 1;
      foreach (q2[i]) if (q2[i].adr == wadr) q2[i].stale = 1;
      st = (arm_d || inj_dbe) ? 2 : ((arm_s || inj_sbe) ? 1 : 0);
      mdata[wadr] = wdat;
      est1[wadr]  = st;
      est2[wadr]  = st;
      arm_s = 0;
      arm_d = 0;
    end else begin
      arm_s = arm_s | inj_sbe;
      arm_d = arm_d | inj_dbe;
    end
    @(posedge clk);
    #1;
    cyc++;
    wen = 0; ren = 0; inj_sbe = 0; inj_dbe = 0; cnt_clr = 0;
  endtask

  task automatic wr(input logic [8:0] a, input logic [79:0] d);
    wen = 1; wadr = a; wdat = d;
    step();
  endtask

  task automatic rd(input logic [8:0] a);
    ren = 1; radr = a;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [79:0] rnd80();
    return {$urandom(), $urandom(), 16'($urandom())};
  endfunction

  initial begin
    checks = 0; errors = 0; cyc = 0;
    arm_s = 0; arm_d = 0; c1s = 0; c1d = 0; c2s = 0; c2d = 0;
    wen = 0; ren = 0; inj_sbe = 0; inj_dbe = 0; scrub_en = 0; cnt_clr = 0;
    wadr = '0; radr = '0; wdat = '0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rvld1", 128'(rvld1), 128'(0));
    chk("rst_rvld2", 128'(rvld2), 128'(0));
    chk("rst_rdat1", 128'(rdat1), 128'(0));
    chk("rst_rdat2", 128'(rdat2), 128'(0));
    chk("rst_cnt1", 128'({sbe_cnt1, dbe_cnt1}), 128'(0));
    chk("rst_drop", 128'({drop1, drop2, rsbe1, rdbe1, rsbe2, rdbe2}), 128'(0));
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // Plain write / read-back.
    wr(9'd5, 80'h1234_5678_9ABC_DEF0_1357);
    rd(9'd5);
    idle(2);

    // Armed SBE, then scrub with an idle write port clears it.
    inj_sbe = 1;
    step();
    wr(9'd7, {80{1'b1}});
    rd(9'd7);
    idle(2);
    chk("sbe_cnt1_after_inj", 128'(sbe_cnt1), 128'(1));
    scrub_en = 1;
    rd(9'd7);
    idle(3);
    rd(9'd7);
    idle(2);

    // DBE injected on the same cycle as the write; never scrubbed.
    inj_dbe = 1;
    wr(9'd9, 80'h0);
    rd(9'd9);
    idle(3);
    rd(9'd9);
    idle(2);
    chk("dbe_cnt1_after_inj", 128'(dbe_cnt1), 128'(2));

    // Back-to-back reads.
    for (int a = 0; a < 4; a++) wr(9'(a), rnd80());
    for (int a = 0; a < 4; a++) rd(9'(a));
    idle(3);

    // Scrub collides with a user write on the output cycle.
    inj_sbe = 1;
    wr(9'd100, rnd80());
    rd(9'd100);
    wr(9'd100, 80'hCAFE_F00D_0000_1111_2222);
    idle(2);
    rd(9'd100);
    idle(2);

    // Address rewritten while the read is in flight: scrub silently suppressed.
    inj_sbe = 1;
    wr(9'd20, rnd80());
    wen = 1; wadr = 9'd20; wdat = rnd80(); ren = 1; radr = 9'd20;
    step();
    idle(3);
    rd(9'd20);
    idle(2);

    // Counter saturation and clear-vs-increment.
    scrub_en = 0;
    cnt_clr = 1;
    step();
    inj_sbe = 1;
    wr(9'd30, rnd80());
    for (int i = 0; i < 5; i++) rd(9'd30);
    idle(3);
    chk("sbe_cnt2_sat", 128'(sbe_cnt2), 128'(3));
    chk("sbe_cnt1_five", 128'(sbe_cnt1), 128'(5));
    rd(9'd30);
    cnt_clr = 1;
    step();
    cnt_clr = 1;
    step();
    idle(1);
    chk("cnt_clr_wins", 128'({sbe_cnt1, sbe_cnt2}), 128'(0));

    // Randomized traffic over a small address window.
    for (int a = 0; a < 16; a++) wr(9'(a), rnd80());
    for (int i = 0; i < 400; i++) begin
      wen      = ($urandom() % 2) == 0;
      wadr     = 9'($urandom() % 16);
      wdat     = rnd80();
      ren      = ($urandom() % 2) == 0;
      radr     = 9'($urandom() % 16);
      inj_sbe  = ($urandom() % 6) == 0;
      inj_dbe  = ($urandom() % 12) == 0;
      scrub_en = ($urandom() % 2) == 0;
      cnt_clr  = ($urandom() % 40) == 0;
      step();
    end
    scrub_en = 0;
    idle(3);

    // Reset while reads are in flight: nothing is delivered afterwards.
    rd(9'd5);
    rd(9'd7);
    rst_n = 0;
    #2;
    chk("midrst_rvld", 128'({rvld1, rvld2}), 128'(0));
    chk("midrst_flags", 128'({rsbe1, rdbe1, rsbe2, rdbe2, drop1, drop2}), 128'(0));
    chk("midrst_rdat", 128'({rdat1, rdat2}), 128'(0));
    chk("midrst_cnt", 128'({sbe_cnt1, dbe_cnt1, sbe_cnt2, dbe_cnt2}), 128'(0));
    q1.delete();
    q2.delete();
    c1s = 0; c1d = 0; c2s = 0; c2d = 0;
    arm_s = 0; arm_d = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    idle(3);
    rd(9'd5);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
